wb_port_arbiter: RTL and testbench

Sequencer for the register-file write port at the end of the writeback stage. It selects the pipeline write value from memory/load data or the ALU result using mem_to_reg, and shares the single write port between the pipeline and the debug unit. A one-entry holding buffer and a stall output let a starving debug write take the port without losing or reordering pipeline writes. Register-file write outputs are registered and feed the register bank directly.

---
 rtl/wb_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. debug writes, registered outputs.
// Optional starvation guard (hold buffer, forced debug slot) enabled by WB_ARB_STARVE_GUARD_EN.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_PIPE  | buffer empty; pipeline and debug compete for the port
//  ST_DRAIN | buffer holds one pipeline write; pipeline stalled
module wb_port_arbiter #(
    parameter int BITS_SIZE     = 32,
    parameter int REG_ADDR_BITS = 5,
    parameter int DBG_MAX_WAIT  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wb_valid,
    input  logic                     i_wb_mem_to_reg,
    input  logic [BITS_SIZE-1:0]     i_wb_data_to_reg,
    input  logic [BITS_SIZE-1:0]     i_wb_alu,
    input  logic [REG_ADDR_BITS-1:0] i_wb_addr,
    input  logic                     i_dbg_req,
    input  logic [REG_ADDR_BITS-1:0] i_dbg_addr,
    input  logic [BITS_SIZE-1:0]     i_dbg_data,
    output logic                     o_dbg_ack,
    output logic                     o_stall,
    output logic                     o_rf_we,
    output logic [REG_ADDR_BITS-1:0] o_rf_addr,
    output logic [BITS_SIZE-1:0]     o_rf_data
);

    logic                     rf_we_q;
    logic [REG_ADDR_BITS-1:0] rf_addr_q;
    logic [BITS_SIZE-1:0]     rf_data_q;
    logic                     ack_q;
    logic                     stall_q;

    logic [BITS_SIZE-1:0]     pipe_data;
    logic                     dbg_req;
    logic                     wr_en;
    logic [REG_ADDR_BITS-1:0] wr_addr;
    logic [BITS_SIZE-1:0]     wr_data;
    logic                     ack_d;
    logic                     stall_d;

    assign pipe_data = i_wb_mem_to_reg ? i_wb_data_to_reg : i_wb_alu;
    // A request still high during its own ack cycle is the one just serviced.
    assign dbg_req   = i_dbg_req & ~ack_q;

`ifdef WB_ARB_STARVE_GUARD_EN
    typedef enum logic {ST_PIPE = 1'b0, ST_DRAIN = 1'b1} state_t;

    localparam logic [7:0] MAX_WAIT = 8'(DBG_MAX_WAIT);

    state_t                   state_q, state_d;
    logic [7:0]               wait_cnt_q, wait_cnt_d;
    logic [REG_ADDR_BITS-1:0] buf_addr_q, buf_addr_d;
    logic [BITS_SIZE-1:0]     buf_data_q, buf_data_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        wr_en      = 1'b0;
        wr_addr    = i_wb_addr;
        wr_data    = pipe_data;
        ack_d      = 1'b0;

        if (!dbg_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        case (state_q)
            ST_DRAIN: begin
                wr_en   = 1'b1;
                wr_addr = buf_addr_q;
                wr_data = buf_data_q;
                state_d = ST_PIPE;
            end
            default: begin
                if (dbg_req && ((wait_cnt_q == MAX_WAIT) || !i_wb_valid)) begin
                    wr_en      = 1'b1;
                    wr_addr    = i_dbg_addr;
                    wr_data    = i_dbg_data;
                    ack_d      = 1'b1;
                    wait_cnt_d = '0;
                    // Forced slot: park the displaced pipeline write for next cycle.
                    if (i_wb_valid) begin
                        buf_addr_d = i_wb_addr;
                        buf_data_d = pipe_data;
                        state_d    = ST_DRAIN;
                    end
                end else if (i_wb_valid) begin
                    wr_en = 1'b1;
                end
            end
        endcase
    end

    assign stall_d = (state_d == ST_DRAIN);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_PIPE;
            wait_cnt_q <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end
`else
    // Without the guard, debug only uses cycles the pipeline leaves idle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = i_wb_addr;
        wr_data = pipe_data;
        ack_d   = 1'b0;
        if (dbg_req && !i_wb_valid) begin
            wr_en   = 1'b1;
            wr_addr = i_dbg_addr;
            wr_data = i_dbg_data;
            ack_d   = 1'b1;
        end else if (i_wb_valid) begin
            wr_en = 1'b1;
        end
    end

    assign stall_d = 1'b0;

    logic unused_max_wait;
    assign unused_max_wait = (DBG_MAX_WAIT != 0);
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            ack_q     <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            // Writes to register 0 still use the slot but never enable the bank.
            rf_we_q <= wr_en && (wr_addr != '0);
            if (wr_en) begin
                rf_addr_q <= wr_addr;
                rf_data_q <= wr_data;
            end
            ack_q   <= ack_d;
            stall_q <= stall_d;
        end
    end

    assign o_rf_we   = rf_we_q;
    assign o_rf_addr = rf_addr_q;
    assign o_rf_data = rf_data_q;
    assign o_dbg_ack = ack_q;
    assign o_stall   = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; expectations follow WB_ARB_STARVE_GUARD_EN if defined.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_m2r;
    logic [31:0] wb_dtr;
    logic [31:0] wb_alu;
    logic [4:0]  wb_addr;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_ack;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int tests_run    = 0;
    int tests_failed = 0;

    wb_port_arbiter #(.BITS_SIZE(32), .REG_ADDR_BITS(5), .DBG_MAX_WAIT(8)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_wb_valid       (wb_valid),
        .i_wb_mem_to_reg  (wb_m2r),
        .i_wb_data_to_reg (wb_dtr),
        .i_wb_alu         (wb_alu),
        .i_wb_addr        (wb_addr),
        .i_dbg_req        (dbg_req),
        .i_dbg_addr       (dbg_addr),
        .i_dbg_data       (dbg_data),
        .o_dbg_ack        (dbg_ack),
        .o_stall          (stall),
        .o_rf_we          (rf_we),
        .o_rf_addr        (rf_addr),
        .o_rf_data        (rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic ack, input logic stl);
        check({tag, ".we"},    32'(rf_we),   32'(we));
        if (we) begin
            check({tag, ".addr"}, 32'(rf_addr), 32'(addr));
            check({tag, ".data"}, rf_data,      data);
        end
        check({tag, ".ack"},   32'(dbg_ack), 32'(ack));
        check({tag, ".stall"}, 32'(stall),   32'(stl));
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          idx;
        logic        stall_before;
        logic        e_we, e_ack, e_stall;
        logic [4:0]  e_addr;
        logic [31:0] e_data;

        rst      = 1'b1;
        wb_valid = 1'b0;
        wb_m2r   = 1'b0;
        wb_dtr   = 32'h0;
        wb_alu   = 32'h0;
        wb_addr  = 5'd0;
        dbg_req  = 1'b0;
        dbg_addr = 5'd0;
        dbg_data = 32'h0;

        #12;
        check("reset.we",    32'(rf_we),   32'd0);
        check("reset.addr",  32'(rf_addr), 32'd0);
        check("reset.data",  rf_data,      32'd0);
        check("reset.ack",   32'(dbg_ack), 32'd0);
        check("reset.stall", 32'(stall),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Pipeline ALU write, then load-data write.
        wb_valid = 1'b1; wb_addr = 5'd3; wb_m2r = 1'b0;
        wb_alu = 32'h0000_00AA; wb_dtr = 32'h5555_5555;
        tick;
        check_out("pipe_alu", 1'b1, 5'd3, 32'h0000_00AA, 1'b0, 1'b0);
        wb_m2r = 1'b1; wb_dtr = 32'h1234_5678; wb_alu = 32'hFFFF_0000;
        tick;
        check_out("pipe_mem", 1'b1, 5'd3, 32'h1234_5678, 1'b0, 1'b0);
        wb_valid = 1'b0;
        tick;
        check_out("idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Debug write on an idle pipeline; request left high through the ack cycle.
        dbg_req = 1'b1; dbg_addr = 5'd7; dbg_data = 32'hDEAD_BEEF;
        tick;
        check_out("dbg_idle", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick;
        check_out("dbg_ack_once", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        dbg_req = 1'b0;

        // Register 0 from the pipeline and from debug.
        wb_valid = 1'b1; wb_addr = 5'd0; wb_m2r = 1'b0; wb_alu = 32'h0000_0011;
        tick;
        check_out("r0_pipe", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        wb_valid = 1'b0; dbg_req = 1'b1; dbg_addr = 5'd0; dbg_data = 32'h0000_0022;
        tick;
        check_out("r0_dbg", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        dbg_req = 1'b0;
        tick;
        check_out("r0_after", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Starvation: pipeline writes Wk = {addr k, 0x100+k} every cycle, debug pending.
        idx = 1;
        wb_valid = 1'b1; wb_m2r = 1'b0;
        dbg_req = 1'b1; dbg_addr = 5'd20; dbg_data = 32'hCAFE_F00D;
        for (int c = 0; c < 12; c++) begin
            wb_addr = 5'(idx);
            wb_alu  = 32'h100 + 32'(idx);
            wb_dtr  = 32'hBAD0_0000 + 32'(idx);
            stall_before = stall;
            tick;
            e_we = 1'b1; e_ack = 1'b0; e_stall = 1'b0;
`ifdef WB_ARB_STARVE_GUARD_EN
            if (c < 8) begin
                e_addr = 5'(c + 1); e_data = 32'h100 + 32'(c + 1);
            end else if (c == 8) begin
                e_addr = 5'd20; e_data = 32'hCAFE_F00D; e_ack = 1'b1; e_stall = 1'b1;
            end else if (c == 9) begin
                e_addr = 5'd9; e_data = 32'h109;
            end else begin
                e_addr = 5'(c); e_data = 32'h100 + 32'(c);
            end
`else
            e_addr = 5'(c + 1); e_data = 32'h100 + 32'(c + 1);
`endif
            check_out($sformatf("starve[%0d]", c), e_we, e_addr, e_data, e_ack, e_stall);
            if (dbg_ack) dbg_req = 1'b0;
            if (!stall_before) idx++;
        end
        wb_valid = 1'b0;
        tick;
`ifdef WB_ARB_STARVE_GUARD_EN
        check_out("starve_end", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
`else
        check_out("starve_end", 1'b1, 5'd20, 32'hCAFE_F00D, 1'b1, 1'b0);
`endif
        dbg_req = 1'b0;
        tick;
        check_out("starve_quiet", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Reset while a pipeline write is buffered; debug request held across reset.
        wb_valid = 1'b1; wb_addr = 5'd5; wb_m2r = 1'b0; wb_alu = 32'h55AA_55AA;
        dbg_req = 1'b1; dbg_addr = 5'd11; dbg_data = 32'h0BAD_CAFE;
        for (int c = 0; c < 9; c++) tick;
`ifdef WB_ARB_STARVE_GUARD_EN
        check("drain.stall", 32'(stall), 32'd1);
        check("drain.ack",   32'(dbg_ack), 32'd1);
`else
        check("drain.stall", 32'(stall), 32'd0);
        check("drain.ack",   32'(dbg_ack), 32'd0);
`endif
        #2 rst = 1'b1;
        #1;
        check("rst_mid.we",    32'(rf_we),   32'd0);
        check("rst_mid.addr",  32'(rf_addr), 32'd0);
        check("rst_mid.data",  rf_data,      32'd0);
        check("rst_mid.ack",   32'(dbg_ack), 32'd0);
        check("rst_mid.stall", 32'(stall),   32'd0);
        wb_valid = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        check_out("rst_dbg_afresh", 1'b1, 5'd11, 32'h0BAD_CAFE, 1'b1, 1'b0);
        dbg_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            check_out($sformatf("rst_nobuf[%0d]", c), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
